// File: rtl/clk_div_stepdown_if.sv
// Step-down handshake and divided-clock bundle for hooking a clk_div_stepdown
// instance up to a controller (master) and to the divider itself (slave).
interface clk_div_stepdown_if;
  logic step_down_req;
  logic step_down_ack;
  logic test_en;
  logic clk_div;

  modport master (
    output step_down_req,
    output test_en,
    input  step_down_ack,
    input  clk_div
  );

  modport slave (
    input  step_down_req,
    input  test_en,
    output step_down_ack,
    output clk_div
  );
endinterface

// File: rtl/clk_div_mux2.sv
// 2:1 clock mux; kept as its own leaf so it can be swapped for a technology cell.
module clk_div_mux2 (
  input  logic sel,
  input  logic clk0,
  input  logic clk1,
  output logic clk_o
);
  always_comb clk_o = sel ? clk1 : clk0;
endmodule

// File: rtl/clk_div_stepdown.sv
// Integer clock divider with a step-down mode that halves the ratio and a
// test bypass forwarding clk_i unchanged.
module clk_div_stepdown #(
  parameter int unsigned Divisor = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic step_down_req_i,
  output logic step_down_ack_o,
  input  logic test_en_i,
  output logic clk_o
);
  localparam int unsigned ToggleCnt = Divisor / 2;
  localparam int unsigned StepCnt   = (ToggleCnt / 2 < 1) ? 1 : ToggleCnt / 2;
  localparam int unsigned CntW      = $clog2(ToggleCnt + 1);

  if ((Divisor < 2) || (Divisor % 2 != 0)) begin : g_bad_divisor
    $error("clk_div_stepdown: Divisor must be even and >= 2");
  end

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_STEP   = 1'b1
  } step_state_t;

  // Power-up values let the output toggle even with rst_ni tied high.
  step_state_t     state_q   = ST_NORMAL;
  step_state_t     state_d;
  logic [CntW-1:0] cnt_q     = '0;
  logic [CntW-1:0] cnt_d;
  logic            clk_int_q = 1'b0;
  logic            clk_int_d;
  logic [CntW-1:0] lim;
  logic            wrap;
  logic            step_q;
  logic            div_clk;

  always_comb begin
    lim  = (state_q == ST_STEP) ? CntW'(StepCnt - 1) : CntW'(ToggleCnt - 1);
    wrap = (cnt_q == lim);
  end

  // Ratio only changes on a half-period boundary, keeping clk_o glitch-free.
  always_comb begin
    state_d = state_q;
    if (wrap) begin
      state_d = step_down_req_i ? ST_STEP : ST_NORMAL;
    end
  end

  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    clk_int_d = clk_int_q;
    if (wrap) begin
      cnt_d     = '0;
      clk_int_d = ~clk_int_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_NORMAL;
      cnt_q     <= '0;
      clk_int_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clk_int_q <= clk_int_d;
    end
  end

  always_comb begin
    step_q          = (state_q == ST_STEP);
    step_down_ack_o = step_q;
  end

  // With Divisor==2 the halved ratio is 1, so step-down passes clk_i through.
  if (Divisor == 2) begin : g_step_bypass
    clk_div_mux2 u_step_mux (
      .sel   (step_q),
      .clk0  (clk_int_q),
      .clk1  (clk_i),
      .clk_o (div_clk)
    );
  end else begin : g_no_step_bypass
    always_comb div_clk = clk_int_q;
  end

  clk_div_mux2 u_test_mux (
    .sel   (test_en_i),
    .clk0  (div_clk),
    .clk1  (clk_i),
    .clk_o (clk_o)
  );
endmodule

// File: tb/tb_clk_div_stepdown.sv
// Scoreboard bench: the driver queues hand-computed per-cycle clk_o/ack values,
// a monitor samples each DUT output after both clock edges and compares.
module tb_clk_div_stepdown;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  clk_div_stepdown_if if4 ();
  clk_div_stepdown_if if8 ();
  clk_div_stepdown_if if2 ();

  initial begin
    if4.step_down_req = 1'b0; if4.test_en = 1'b0;
    if8.step_down_req = 1'b0; if8.test_en = 1'b0;
    if2.step_down_req = 1'b0; if2.test_en = 1'b0;
  end

  clk_div_stepdown #(.Divisor(4)) u_div4 (
    .clk_i(clk), .rst_ni(rst_n), .step_down_req_i(if4.step_down_req),
    .step_down_ack_o(if4.step_down_ack), .test_en_i(if4.test_en), .clk_o(if4.clk_div));
  clk_div_stepdown #(.Divisor(8)) u_div8 (
    .clk_i(clk), .rst_ni(rst_n), .step_down_req_i(if8.step_down_req),
    .step_down_ack_o(if8.step_down_ack), .test_en_i(if8.test_en), .clk_o(if8.clk_div));
  clk_div_stepdown #(.Divisor(2)) u_div2 (
    .clk_i(clk), .rst_ni(rst_n), .step_down_req_i(if2.step_down_req),
    .step_down_ack_o(if2.step_down_ack), .test_en_i(if2.test_en), .clk_o(if2.clk_div));

  typedef struct {
    int    dut;
    string nm;
    logic  hi;
    logic  lo;
    logic  ack;
  } exp_t;

  exp_t exp_q[$];

  function automatic logic out_clk(input int d);
    case (d)
      0:       return if4.clk_div;
      1:       return if8.clk_div;
      default: return if2.clk_div;
    endcase
  endfunction

  function automatic logic out_ack(input int d);
    case (d)
      0:       return if4.step_down_ack;
      1:       return if8.step_down_ack;
      default: return if2.step_down_ack;
    endcase
  endfunction

  task automatic set_in(input int d, input logic req, input logic ten);
    case (d)
      0:       begin if4.step_down_req = req; if4.test_en = ten; end
      1:       begin if8.step_down_req = req; if8.test_en = ten; end
      default: begin if2.step_down_req = req; if2.test_en = ten; end
    endcase
  endtask

  task automatic cmp(input string nm, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, req, $time);
    end
  endtask

  // Vectors are MSB-first: bit n-1 is the first cycle of the sequence.
  task automatic seq(input int d, input string nm, input int n,
                     input logic [31:0] rv, input logic [31:0] qv,
                     input logic [31:0] tv, input logic [31:0] hv,
                     input logic [31:0] lv, input logic [31:0] av);
    logic prev_rst;
    exp_t e;
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      #3;
      prev_rst = rst_n;
      rst_n = rv[i];
      set_in(d, qv[i], tv[i]);
      e.dut = d; e.nm = nm; e.hi = hv[i]; e.lo = lv[i]; e.ack = av[i];
      exp_q.push_back(e);
      if (prev_rst && !rv[i] && !tv[i]) begin
        #1;
        cmp({nm, "_async_rst_clk"}, out_clk(d), 1'b0);
        cmp({nm, "_async_rst_ack"}, out_ack(d), 1'b0);
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp({e.nm, "_clk_hi"}, out_clk(e.dut), e.hi);
        cmp({e.nm, "_ack"},    out_ack(e.dut), e.ack);
        @(negedge clk);
        #1;
        cmp({e.nm, "_clk_lo"}, out_clk(e.dut), e.lo);
      end
    end
  end

  initial begin : driver
    int budget;
    // Div4: reset (first cycle in bypass), then period 4
    seq(0, "d4_normal", 12, 12'b001111111111, 12'b0, 12'b100000000000,
        12'b100110011001, 12'b000110011001, 12'b0);
    // Div4: req mid half-period, step applies at wrap, then drop req
    seq(0, "d4_step", 9, 9'h1FF, 9'b111100000, 9'b0,
        9'b101011001, 9'b101011001, 9'b011100000);
    // Div4: reset mid-operation while stepped down
    seq(0, "d4_reset", 8, 8'b11101111, 8'b11100000, 8'b0,
        8'b10100110, 8'b10100110, 8'b01100000);
    // Div8: period 8 -> 4 -> 8
    seq(1, "d8_step", 18, 18'b001111111111111111, 18'b000011110000000000, 18'b0,
        18'b000001100111100001, 18'b000001100111100001, 18'b000001111000000000);
    // Div8: test bypass, then divided output resumes in counter phase
    seq(1, "d8_bypass", 8, 8'hFF, 8'b0, 8'b11100000,
        8'b11100001, 8'b00000001, 8'b0);
    // Div2: divide-by-2, step-down passes clk_i, then back
    seq(2, "d2_step", 10, 10'b0011111111, 10'b0000111000, 10'b0,
        10'b0010111010, 10'b0010000010, 10'b0000111000);

    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clk_div_stepdown.md
Name: clk_div_stepdown

Overview:
- Integer clock divider with an optional "step-down" mode that halves the division ratio. Step-down is used when the source clock has itself been slowed, so the output frequency stays nominal.
- Sits at chip or testbench level. Its main use is deriving a slow always-on clock (clk_aon) from the main clock; the default system build uses Divisor=4.
- Includes a test bypass that forwards the input clock unchanged.

Parameters:
- Divisor, default 2: normal division ratio. Must be even and >= 2; elaboration fails otherwise.
- ToggleCnt (localparam) = Divisor/2: input cycles per output half-period.
- StepCnt (localparam) = max(1, ToggleCnt/2): half-period count in step-down mode.

Ports:
- clk_i  in  1  source clock; all logic on its rising edge.
- rst_ni  in  1  reset; one clock, reset is asynchronous and active-low.
- step_down_req_i  in  1  request to halve the division ratio; level-sensitive.
- step_down_ack_o  out  1  high while step-down ratio is in effect.
- test_en_i  in  1  test bypass; clk_o = clk_i while high.
- clk_o  out  1  divided clock.

Behaviour:
- Reset (rst_ni low):
  - cnt = 0, clk_int = 0, step_q = 0, step_down_ack_o = 0.
  - clk_o = 0 unless test_en_i = 1.
- Simulation without reset: all registers carry an initial value of 0. This is required because rst_ni may be tied high, and the output must still toggle from time zero.
- Core state: counter cnt of width $clog2(ToggleCnt+1), output flop clk_int, registered step-down state step_q.
- Half-period limit: lim = (step_q ? StepCnt : ToggleCnt) - 1.
- Each clk_i rising edge:
  - If cnt == lim: cnt <= 0, clk_int <= ~clk_int, step_q <= step_down_req_i.
  - Else: cnt <= cnt + 1.
- Glitch-free mode change: the ratio changes only at a half-period boundary, i.e. when cnt wraps.
- Ack: step_down_ack_o = step_q, a registered output.
  - Asserts at the first wrap that samples req = 1.
  - Deasserts at the first wrap that samples req = 0.
- Normal output: clk_o period = Divisor input cycles, 50% duty. First rising edge at cycle ToggleCnt after reset release.
- Step-down output: period = 2*StepCnt input cycles.
- Divisor == 2 special case:
  - Normal: clk_int toggles every cycle, giving divide-by-2.
  - Step-down: clk_o = clk_i (ratio 1), selected through a clock mux whose select is step_q.
  - step_q updates only on a cycle where clk_int has just toggled.
- Bypass: test_en_i = 1 forces clk_o = clk_i combinationally (clock mux). The internal counter keeps running.
- Toggling req mid half-period has no effect until the next wrap.
- Asserting reset mid-operation immediately returns clk_o low and clears ack.
- No combinational path from step_down_req_i to any output.

Decomposition:
- No shared package; all constants are local parameters.
- One natural leaf: clk_div_mux2. It is a 2:1 clock mux (sel, clk0, clk1 -> clk_o), reused for the step-down bypass (Divisor==2) and for test_en bypass, and kept separate so it can be replaced by a technology cell.

Test Plan:
- Divisor=4, req=0, test_en=0, release reset → clk_o = 0 for 2 cycles, 1 for 2 cycles, repeating (period 4); ack stays 0.
- Divisor=4, assert req mid half-period → change applies only at the next cnt wrap, ack rises at that same edge, then clk_o toggles every cycle (period 2).
- Divisor=8 with req, then deassert req → period goes 8 → 4 → 8, with the 8 → 4 transition occurring at a wrap; ack follows the wrap-sampled req; no high or low pulse shorter than 2 cycles.
- Divisor=2, req=1 → after the next toggle, clk_o matches clk_i and ack = 1; deassert req → divide-by-2 resumes.
- test_en_i=1 with any Divisor → clk_o identical to clk_i; drop test_en → divided output resumes in phase with the internal counter.
- Assert rst_ni low mid-period → clk_o = 0 and ack = 0 immediately; after release, the first rising edge of clk_o comes ToggleCnt cycles later.
